// File: rtl/memory_banked_rw.sv
// memory_banked_rw: single-port word memory with valid/done handshake,
// byte-lane write masks and a fixed access latency of LATENCY wait cycles.
// Ports: clk, rst_n (sync, active low); request mem_valid/mem_addr/
// mem_wdata/mem_wstrobe/mem_wmask; response mem_rdata/mem_done and,
// when the MEMORY_ERR_EN macro is defined, mem_err (out-of-range flag).
// Parameters: WIDTH, DEPTH, LATENCY (>= 1), INIT_F (init file name).
module memory_banked_rw #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 1,
  parameter     INIT_F  = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [WIDTH-1:0]   mem_wdata,
  input  logic               mem_wstrobe,
  input  logic [WIDTH/8-1:0] mem_wmask,
  output logic [WIDTH-1:0]   mem_rdata,
  output logic               mem_done
`ifdef MEMORY_ERR_EN
  ,
  output logic               mem_err
`endif
);

  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    req_idx;
  logic             req_oor;
  logic             req_wr;
  logic [WIDTH-1:0] req_wdata;
  logic [NB-1:0]    req_wmask;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [31:0] addr_hi;
  logic        idx_oor;
  logic        addr_oor;

  assign addr_hi = mem_addr >> (AW + 2);

  if (DEPTH == (1 << AW)) begin : g_pow2
    assign idx_oor = 1'b0;
  end else begin : g_npow2
    assign idx_oor =
      32'(mem_addr[AW+1:2]) >= 32'(DEPTH);
  end

  assign addr_oor = (addr_hi != '0) || idx_oor;

  logic access;
  assign access = (state == BUSY) && (count == '0);

  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] resp_word;

  assign cur_word = mem[req_idx];

  always_comb begin
    merged = cur_word;
    if (req_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask[b]) begin
          merged[8*b +: 8] = req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign resp_word = req_oor ? '0 : merged;

  always_ff @(posedge clk) begin
    if (rst_n && access && req_wr && !req_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      req_idx   <= '0;
      req_oor   <= 1'b0;
      req_wr    <= 1'b0;
      req_wdata <= '0;
      req_wmask <= '0;
`ifdef MEMORY_ERR_EN
      mem_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          mem_done <= 1'b0;
`ifdef MEMORY_ERR_EN
          mem_err  <= 1'b0;
`endif
          if (mem_valid) begin
            req_idx   <= mem_addr[AW+1:2];
            req_oor   <= addr_oor;
            req_wr    <= mem_wstrobe;
            req_wdata <= mem_wdata;
            req_wmask <= mem_wmask;
            count     <= CW'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            mem_rdata <= resp_word;
            mem_done  <= 1'b1;
`ifdef MEMORY_ERR_EN
            mem_err   <= req_oor;
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          mem_done <= 1'b0;
`ifdef MEMORY_ERR_EN
          mem_err  <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_banked_rw.sv
// Bench for memory_banked_rw: two instances (DEPTH=16/LATENCY=1 and
// DEPTH=64/LATENCY=3) checked against a word-array reference model.
module tb_memory_banked_rw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       valid;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       wstrobe;
  logic [1:0][3:0]  wmask;
  logic [1:0][31:0] rdata;
  logic [1:0]       done;
  logic [1:0]       err;

  int n_cmp = 0;
  int n_bad = 0;

  int depth [2] = '{16, 64};
  int lat   [2] = '{1, 3};
  logic [31:0] model [2][64];

  memory_banked_rw #(
    .WIDTH(32), .DEPTH(16), .LATENCY(1), .INIT_F("")
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrobe(wstrobe[0]),
    .mem_wmask(wmask[0]), .mem_rdata(rdata[0]),
    .mem_done(done[0])
`ifdef MEMORY_ERR_EN
    , .mem_err(err[0])
`endif
  );

  memory_banked_rw #(
    .WIDTH(32), .DEPTH(64), .LATENCY(3), .INIT_F("")
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrobe(wstrobe[1]),
    .mem_wmask(wmask[1]), .mem_rdata(rdata[1]),
    .mem_done(done[1])
`ifdef MEMORY_ERR_EN
    , .mem_err(err[1])
`endif
  );

`ifndef MEMORY_ERR_EN
  assign err = 2'b00;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake; cyc = edges from raising valid to seeing done.
  task automatic req(input int d, input logic [31:0] a,
                     input logic [31:0] wd, input logic wr,
                     input logic [3:0] mk,
                     output logic [31:0] rd, output logic er,
                     output int cyc);
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd;
    wstrobe[d] = wr; wmask[d] = mk;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done[d] && cyc < 40);
    rd = rdata[d];
    er = err[d];
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  // Expected response from the model, then the model update.
  task automatic op(input int d, input logic [31:0] a,
                    input logic [31:0] wd, input logic wr,
                    input logic [3:0] mk, input string tag,
                    output logic [31:0] rd);
    logic [31:0] exp;
    logic        oor;
    logic        er;
    int          cyc;
    int          idx;
    idx = int'(a >> 2);
    oor = (a >> 2) >= 32'(depth[d]);
    if (oor) begin
      exp = 32'h0;
    end else begin
      exp = model[d][idx];
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) exp[8*b +: 8] = wd[8*b +: 8];
        model[d][idx] = exp;
      end
    end
    req(d, a, wd, wr, mk, rd, er, cyc);
    chk({tag, ".lat"}, 32'(cyc), 32'(lat[d] + 1));
    chk({tag, ".rdata"}, rd, exp);
`ifdef MEMORY_ERR_EN
    chk({tag, ".err"}, 32'(er), 32'(oor));
`endif
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int d;
    rst_n = 1'b0;
    valid = '0; addr = '0; wdata = '0;
    wstrobe = '0; wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst.done", 32'(done[i]), 32'h0);
      chk("rst.rdata", rdata[i], 32'h0);
      chk("rst.err", 32'(err[i]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < depth[i]; w++)
        op(i, 32'(w * 4), $urandom, 1'b1, 4'hF, "fill", rd);

    // Full write, read back.
    op(0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, "t1.wr", rd);
    op(0, 32'h10, 32'h0, 1'b0, 4'h0, "t1.rd", rd);
    chk("t1.val", rd, 32'hDEADBEEF);

    // Single lane write.
    op(0, 32'h10, 32'h0000AA00, 1'b1, 4'b0010, "t2.wr", rd);
    chk("t2.wresp", rd, 32'hDEADAAEF);
    op(0, 32'h11, 32'h0, 1'b0, 4'hF, "t2.rd", rd);
    chk("t2.val", rd, 32'hDEADAAEF);

    // Zero mask write leaves the word unchanged.
    op(0, 32'h10, 32'hFFFFFFFF, 1'b1, 4'h0, "mask0", rd);
    chk("mask0.val", rd, 32'hDEADAAEF);

    // Out of range on the 16-word instance.
    op(0, 32'h40, 32'h12345678, 1'b1, 4'hF, "t4.wr", rd);
    op(0, 32'h40, 32'h0, 1'b0, 4'h0, "t4.rd", rd);
    op(0, 32'h0, 32'h0, 1'b0, 4'h0, "t4.alias", rd);

    // Back-to-back sequence.
    op(0, 32'h0, 32'h1, 1'b1, 4'hF, "t5.w0", rd);
    op(0, 32'h4, 32'h2, 1'b1, 4'hF, "t5.w1", rd);
    op(0, 32'h8, 32'h3, 1'b1, 4'hF, "t5.w2", rd);
    op(0, 32'h0, 32'h0, 1'b0, 4'h0, "t5.r0", rd);
    chk("t5.v0", rd, 32'h1);
    op(0, 32'h4, 32'h0, 1'b0, 4'h0, "t5.r1", rd);
    chk("t5.v1", rd, 32'h2);
    op(0, 32'h8, 32'h0, 1'b0, 4'h0, "t5.r2", rd);
    chk("t5.v2", rd, 32'h3);

    // Valid held: done one cycle wide every LATENCY+2 edges.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h10;
    wstrobe[1] = 1'b0; wmask[1] = 4'h0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      chk("t3.done", 32'(done[1]),
          32'((e == lat[1] + 1) || (e == 2 * lat[1] + 3)));
      if (done[1]) chk("t3.rdata", rdata[1], model[1][4]);
    end
    @(negedge clk);
    valid[1] = 1'b0;

    // Reset one cycle after accepting a write.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h20;
    wdata[1] = 32'hFFFFFFFF; wstrobe[1] = 1'b1;
    wmask[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    valid[1] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      chk("t6.done", 32'(done[1]), 32'h0);
      chk("t6.rdata", rdata[1], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 32'h20, 32'h0, 1'b0, 4'h0, "t6.rd", rd);

    // Random traffic on both instances.
    for (int k = 0; k < 150; k++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = $urandom | 32'h0010_0000;
      else
        a = (32'($urandom_range(0, depth[d] - 1)) << 2)
            | 32'($urandom_range(0, 3));
      op(d, a, $urandom, 1'($urandom),
         4'($urandom), "rand", rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
